// File: rtl/matrix_3x3_gen.sv
// Sliding 3x3 window generator for a raster 8-bit video stream.
// Two line buffers plus column shift taps; top two rows and left two columns are zero-padded.
module matrix_3x3_gen #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned ADDR_W   = 11
) (
  input  logic       video_clk,
  input  logic       rst_n,
  input  logic       pre_vs,
  input  logic       pre_de,
  input  logic [7:0] pre_data,
  output logic       matrix_vs,
  output logic       matrix_de,
  output logic [7:0] matrix11,
  output logic [7:0] matrix12,
  output logic [7:0] matrix13,
  output logic [7:0] matrix21,
  output logic [7:0] matrix22,
  output logic [7:0] matrix23,
  output logic [7:0] matrix31,
  output logic [7:0] matrix32,
  output logic [7:0] matrix33
);

  // One extra bit so the counter can hold H_ACTIVE itself as the "over-long" marker.
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [CNT_W-1:0]  col_cnt;
  logic [1:0]        row_cnt;
  logic              vs_d1, vs_d2, de_d1, de_d2;
  logic              vs_rise, de_fall;
  logic [CNT_W-1:0]  cur_col;
  logic [1:0]        cur_row;
  logic              in_range;
  logic [ADDR_W-1:0] addr;

  logic [7:0] lb1 [H_ACTIVE];
  logic [7:0] lb2 [H_ACTIVE];
  logic [7:0] lb1_rd, lb2_rd, row3_q;
  logic       zero_r1_q, zero_r2_q;
  logic [7:0] tap1, tap2, tap3;

  // A frame-sync rising edge overrides the counters for the pixel in the same cycle.
  always_comb begin
    vs_rise  = pre_vs & ~vs_d1;
    de_fall  = ~pre_de & de_d1;
    cur_col  = vs_rise ? '0 : col_cnt;
    cur_row  = vs_rise ? 2'd0 : row_cnt;
    in_range = cur_col < CNT_W'(H_ACTIVE);
    addr     = cur_col[ADDR_W-1:0];
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= 2'd0;
    end else if (vs_rise) begin
      col_cnt <= pre_de ? CNT_W'(1) : '0;
      row_cnt <= 2'd0;
    end else if (pre_de) begin
      if (col_cnt < CNT_W'(H_ACTIVE)) col_cnt <= col_cnt + CNT_W'(1);
    end else if (de_fall) begin
      col_cnt <= '0;
      if (row_cnt != 2'd2) row_cnt <= row_cnt + 2'd1;
    end
  end

  // Line buffers: read-before-write at the same address, lb1 cascades into lb2.
  always_ff @(posedge video_clk) begin
    lb1_rd <= lb1[addr];
    lb2_rd <= lb2[addr];
    if (pre_de && in_range) begin
      lb1[addr] <= pre_data;
      lb2[addr] <= lb1[addr];
    end
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      row3_q    <= 8'd0;
      zero_r1_q <= 1'b0;
      zero_r2_q <= 1'b0;
      vs_d1     <= 1'b0;
      de_d1     <= 1'b0;
      vs_d2     <= 1'b0;
      de_d2     <= 1'b0;
    end else begin
      row3_q    <= pre_data;
      zero_r1_q <= ~in_range | (cur_row != 2'd2);
      zero_r2_q <= ~in_range | (cur_row == 2'd0);
      vs_d1     <= pre_vs;
      de_d1     <= pre_de;
      vs_d2     <= vs_d1;
      de_d2     <= de_d1;
    end
  end

  always_comb begin
    tap1 = zero_r1_q ? 8'd0 : lb2_rd;
    tap2 = zero_r2_q ? 8'd0 : lb1_rd;
    tap3 = row3_q;
  end

  // Clearing on de-low gives the left padding at each line start.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      {matrix11, matrix12, matrix13} <= '0;
      {matrix21, matrix22, matrix23} <= '0;
      {matrix31, matrix32, matrix33} <= '0;
    end else if (de_d1) begin
      {matrix11, matrix12, matrix13} <= {matrix12, matrix13, tap1};
      {matrix21, matrix22, matrix23} <= {matrix22, matrix23, tap2};
      {matrix31, matrix32, matrix33} <= {matrix32, matrix33, tap3};
    end else begin
      {matrix11, matrix12, matrix13} <= '0;
      {matrix21, matrix22, matrix23} <= '0;
      {matrix31, matrix32, matrix33} <= '0;
    end
  end

  assign matrix_vs = vs_d2;
  assign matrix_de = de_d2;

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Directed bench for matrix_3x3_gen with H_ACTIVE=8: window contents, sync latency,
// frame-start padding, stale-buffer suppression, mid-frame reset and over-long lines.
module tb_matrix_3x3_gen;
  localparam int H = 8;

  logic       video_clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pre_vs = 1'b0;
  logic       pre_de = 1'b0;
  logic [7:0] pre_data = 8'd0;
  logic       matrix_vs, matrix_de;
  logic [7:0] matrix11, matrix12, matrix13;
  logic [7:0] matrix21, matrix22, matrix23;
  logic [7:0] matrix31, matrix32, matrix33;

  matrix_3x3_gen #(.H_ACTIVE(8), .ADDR_W(3)) dut (
    .video_clk(video_clk), .rst_n(rst_n),
    .pre_vs(pre_vs), .pre_de(pre_de), .pre_data(pre_data),
    .matrix_vs(matrix_vs), .matrix_de(matrix_de),
    .matrix11(matrix11), .matrix12(matrix12), .matrix13(matrix13),
    .matrix21(matrix21), .matrix22(matrix22), .matrix23(matrix23),
    .matrix31(matrix31), .matrix32(matrix32), .matrix33(matrix33)
  );

  always #5 video_clk = ~video_clk;

  wire [71:0] dut_win = {matrix11, matrix12, matrix13, matrix21, matrix22, matrix23,
                         matrix31, matrix32, matrix33};

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Pixels sent in the current frame, and observed windows per (frame, row, col).
  logic [7:0]  img [0:15][0:15];
  logic [71:0] obs [0:7][0:3][0:15];

  typedef struct {
    logic        de;
    logic        vs;
    logic [71:0] win;
    int          fr;
    int          r;
    int          c;
  } exp_t;

  exp_t pipe0, pipe1;
  int   frame_id = 0;
  int   cur_row = 0;

  // Pixel at (rr, cc) as seen in window row i; buffered rows lose columns past H.
  function automatic logic [7:0] tap(input int rr, input int cc, input int i);
    if (rr < 0 || cc < 0) return 8'd0;
    if (i < 2 && cc >= H) return 8'd0;
    return img[rr][cc];
  endfunction

  function automatic logic [71:0] win_at(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w = {w[63:0], tap(r - 2 + i, c - 2 + j, i)};
    return w;
  endfunction

  task automatic idle_pipes();
    pipe0.de = 1'b0; pipe0.vs = 1'b0; pipe0.win = '0; pipe0.fr = 0; pipe0.r = 0; pipe0.c = 0;
    pipe1 = pipe0;
  endtask

  // One clock: check outputs owed from two ticks ago, then drive the next inputs.
  task automatic tick(input logic vs, input logic de, input logic [7:0] d,
                      input int r, input int c);
    @(posedge video_clk);
    #1;
    check("de", 72'(matrix_de), 72'(pipe1.de));
    check("vs", 72'(matrix_vs), 72'(pipe1.vs));
    check("win", dut_win, pipe1.win);
    if (pipe1.de) obs[pipe1.fr][pipe1.r][pipe1.c] = dut_win;
    pipe1 = pipe0;
    pre_vs = vs;
    pre_de = de;
    pre_data = d;
    if (de) img[r][c] = d;
    pipe0.de = de;
    pipe0.vs = vs;
    pipe0.win = de ? win_at(r, c) : 72'd0;
    pipe0.fr = frame_id;
    pipe0.r = r;
    pipe0.c = c;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 8'd0, 0, 0);
  endtask

  task automatic start_frame(input int id, input int vs_len);
    frame_id = id;
    cur_row = 0;
    repeat (vs_len) tick(1'b1, 1'b0, 8'd0, 0, 0);
    idle(2);
  endtask

  // vs_first raises pre_vs on the first three pixels; mark replaces pixel 0 with 5A.
  task automatic send_line(input int len, input int base, input int step, input int gap,
                           input logic vs_first, input logic mark);
    logic [7:0] px;
    for (int c = 0; c < len; c++) begin
      px = (mark && c == 0) ? 8'h5A : 8'(base + step * c);
      tick(vs_first && c < 3, 1'b1, px, cur_row, c);
    end
    idle(gap);
    cur_row++;
  endtask

  task automatic do_reset();
    @(posedge video_clk);
    #1;
    rst_n = 1'b0;
    pre_vs = 1'b0;
    pre_de = 1'b0;
    pre_data = 8'd0;
    #2;
    check("rst_win", dut_win, 72'd0);
    check("rst_sync", 72'({matrix_de, matrix_vs}), 72'd0);
    @(posedge video_clk);
    #1;
    check("rst_hold", dut_win, 72'd0);
    rst_n = 1'b1;
    idle_pipes();
  endtask

  initial begin
    idle_pipes();
    #1 rst_n = 1'b0;
    #3;
    check("por_win", dut_win, 72'd0);
    check("por_sync", 72'({matrix_de, matrix_vs}), 72'd0);
    @(posedge video_clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Frame 1: pixel = 16*row + col, 2 clk blanking.
    start_frame(1, 3);
    for (int r = 0; r < 4; r++) send_line(8, 16 * r, 1, 2, 1'b0, 1'b0);
    idle(2);
    check("f1_r2c3", obs[1][2][3], 72'h010203_111213_212223);
    check("f1_r0c0", obs[1][0][0], 72'h0);
    check("f1_r1c1", obs[1][1][1], 72'h000000_000001_001011);

    // Frame 2: all FF, back-to-back lines with 1 clk blanking.
    start_frame(2, 3);
    for (int r = 0; r < 4; r++) send_line(8, 8'hFF, 0, 1, 1'b0, 1'b0);
    idle(1);

    // Frame 3: zeros with 5A marker, vs rising together with the first pixel.
    frame_id = 3;
    cur_row = 0;
    send_line(8, 0, 0, 2, 1'b1, 1'b1);
    for (int r = 1; r < 4; r++) send_line(8, 0, 0, 2, 1'b0, 1'b0);
    idle(2);
    check("f3_r0c0", obs[3][0][0], 72'h5A);
    check("f3_r1c0", obs[3][1][0], 72'h000000_00005A_000000);
    check("f3_r1c7", obs[3][1][7], 72'h0);

    // Frame 4 interrupted by reset in line 2, then frame 5 restarts.
    start_frame(4, 3);
    send_line(8, 8'h20, 1, 2, 1'b0, 1'b0);
    send_line(8, 8'h30, 1, 2, 1'b0, 1'b0);
    send_line(4, 8'h40, 1, 0, 1'b0, 1'b0);
    do_reset();
    idle(2);
    start_frame(5, 3);
    send_line(8, 8'h80, 1, 1, 1'b0, 1'b0);
    send_line(8, 8'h90, 1, 2, 1'b0, 1'b0);
    idle(2);
    check("f5_r0c2", obs[5][0][2], 72'h000000_000000_808182);
    check("f5_r1c2", obs[5][1][2], 72'h000000_808182_909192);

    // Frame 6: two over-long lines followed by normal lines.
    start_frame(6, 3);
    send_line(10, 8'h40, 1, 2, 1'b0, 1'b0);
    send_line(10, 8'h60, 1, 2, 1'b0, 1'b0);
    send_line(8, 8'h80, 1, 2, 1'b0, 1'b0);
    send_line(8, 8'hA0, 1, 2, 1'b0, 1'b0);
    idle(3);
    check("f6_r1c9", obs[6][1][9], 72'h000000_470000_676869);
    check("f6_r2c7", obs[6][2][7], 72'h454647_656667_858687);
    check("f6_r3c1", obs[6][3][1], 72'h006061_008081_00A0A1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
